hex_display_arbiter: RTL and testbench

Shares the bank of 7-segment hex display PIO slaves between two requesters, for example the price display and the change/status display of the vending controller. It accepts a 4-bit-per-digit (BCD) value from whichever requester wins round-robin arbitration and encodes each digit to an active-low segment pattern. It then issues one Avalon-MM write per digit to the `out_hex*` PIO slaves, and acknowledges the requester once the whole value is on the displays.

---
 rtl/hex_display_arbiter.sv | 140 ++++++++++++++
 tb/tb_hex_display_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_arbiter.sv
// rtl/hex_display_arbiter.sv - round-robin arbiter driving BCD values onto 7-segment hex PIO slaves
module hex_display_arbiter #(
    parameter int NUM_DIGITS    = 4,
    parameter bit BLANK_LEADING = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_a,
    input  logic [4*NUM_DIGITS-1:0] data_a,
    output logic                    ack_a,
    input  logic                    req_b,
    input  logic [4*NUM_DIGITS-1:0] data_b,
    output logic                    ack_b,
    output logic [NUM_DIGITS-1:0]   hex_chipselect,
    output logic [1:0]              hex_address,
    output logic                    hex_write_n,
    output logic [6:0]              hex_writedata,
    output logic                    busy
);

    localparam int         W        = 4 * NUM_DIGITS;
    localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, ACK} state_t;

    state_t                state;
    logic                  gnt_b;
    logic                  last_b;
    logic                  win_b;
    logic [2:0]            idx;
    logic [2:0]            idx_nxt;
    logic [W-1:0]          data_r;
    logic [W-1:0]          sel_data;
    logic [W-1:0]          data_sh;
    logic [NUM_DIGITS-1:0] keep_r;
    logic [NUM_DIGITS-1:0] keep_c;
    logic [NUM_DIGITS-1:0] keep_sh;
    logic                  seen;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h3F;
        endcase
    endfunction

    // The address register of the PIO slaves is always register 0.
    assign hex_address = 2'b00;

    // B wins only if A is idle or A was the previous grantee.
    assign win_b    = req_b & (~req_a | ~last_b);
    assign sel_data = gnt_b ? data_b : data_a;

    // Digit i is shown when it or any higher nibble is non-zero; digit 0 always shown.
    always_comb begin
        keep_c = '0;
        seen   = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            seen      = seen | (|sel_data[4*i +: 4]);
            keep_c[i] = seen | (i == 0) | !BLANK_LEADING;
        end
    end

    // Next digit's nibble and blank flag, taken from the latched copy.
    always_comb begin
        idx_nxt = idx + 3'd1;
        data_sh = data_r >> {idx_nxt, 2'b00};
        keep_sh = keep_r >> idx_nxt;
    end

    // Transfer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            gnt_b          <= 1'b0;
            last_b         <= 1'b1;
            idx            <= 3'd0;
            data_r         <= '0;
            keep_r         <= '0;
            ack_a          <= 1'b0;
            ack_b          <= 1'b0;
            busy           <= 1'b0;
            hex_chipselect <= '0;
            hex_write_n    <= 1'b1;
            hex_writedata  <= 7'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (req_a | req_b) begin
                        gnt_b  <= win_b;
                        last_b <= win_b;
                        busy   <= 1'b1;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    data_r         <= sel_data;
                    keep_r         <= keep_c;
                    idx            <= 3'd0;
                    hex_chipselect <= NUM_DIGITS'(1);
                    hex_write_n    <= 1'b0;
                    hex_writedata  <= seg7(sel_data[3:0]);
                    state          <= WRITE;
                end
                WRITE: begin
                    if (idx == LAST_IDX) begin
                        hex_chipselect <= '0;
                        hex_write_n    <= 1'b1;
                        hex_writedata  <= 7'h00;
                        ack_a          <= ~gnt_b;
                        ack_b          <= gnt_b;
                        state          <= ACK;
                    end else begin
                        idx            <= idx_nxt;
                        hex_chipselect <= NUM_DIGITS'(1) << idx_nxt;
                        hex_writedata  <= keep_sh[0] ? seg7(data_sh[3:0]) : SEG_BLANK;
                    end
                end
                ACK: begin
                    ack_a <= 1'b0;
                    ack_b <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hex_display_arbiter.sv
// tb/tb_hex_display_arbiter.sv - scoreboard bench for hex_display_arbiter
module tb_hex_display_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_a, req_b, ack_a, ack_b;
    logic [15:0] data_a, data_b;
    logic [3:0]  cs;
    logic [1:0]  addr;
    logic        write_n, busy;
    logic [6:0]  wd;

    logic        req1_a, req1_b, ack1_a, ack1_b;
    logic [15:0] data1_a, data1_b;
    logic [3:0]  cs1;
    logic [1:0]  addr1;
    logic        write1_n, busy1;
    logic [6:0]  wd1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [10:0] wq0[$];
    logic [10:0] wq1[$];
    logic [1:0]  aq0[$];
    int          ack_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    hex_display_arbiter #(.NUM_DIGITS(4), .BLANK_LEADING(1)) dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .data_a(data_a), .ack_a(ack_a),
        .req_b(req_b), .data_b(data_b), .ack_b(ack_b),
        .hex_chipselect(cs), .hex_address(addr), .hex_write_n(write_n),
        .hex_writedata(wd), .busy(busy)
    );

    hex_display_arbiter #(.NUM_DIGITS(4), .BLANK_LEADING(0)) dut_nb (
        .clk(clk), .reset(reset),
        .req_a(req1_a), .data_a(data1_a), .ack_a(ack1_a),
        .req_b(req1_b), .data_b(data1_b), .ack_b(ack1_b),
        .hex_chipselect(cs1), .hex_address(addr1), .hex_write_n(write1_n),
        .hex_writedata(wd1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg(input logic [3:0] n);
        logic [6:0] tbl [16];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
        return tbl[n];
    endfunction

    // Expected four writes for one value, into the queue of the chosen instance.
    function automatic void push_val(input logic [15:0] d, input bit blank, input bit to_nb);
        int msd;
        logic [6:0] p;
        msd = 0;
        for (int i = 0; i < 4; i++) if (d[4*i +: 4] != 4'd0) msd = i;
        for (int i = 0; i < 4; i++) begin
            p = (blank && i > msd) ? 7'h7F : seg(d[4*i +: 4]);
            if (to_nb) wq1.push_back({4'(1 << i), p});
            else       wq0.push_back({4'(1 << i), p});
        end
    endfunction

    // Output monitor: pop expected writes/acks as the DUTs produce them.
    always @(negedge clk) begin
        if (!write_n) begin
            if (wq0.size() == 0) check("wr_unexpected", {21'd0, cs, wd}, 32'd0);
            else                 check("wr", {21'd0, cs, wd}, {21'd0, wq0.pop_front()});
        end
        if (ack_a | ack_b) begin
            ack_cyc.push_back(cyc);
            if (aq0.size() == 0) check("ack_unexpected", {30'd0, ack_a, ack_b}, 32'd0);
            else                 check("ack_who", {30'd0, ack_a, ack_b}, {30'd0, aq0.pop_front()});
        end
        if (!write1_n) begin
            if (wq1.size() == 0) check("nb_wr_unexpected", {21'd0, cs1, wd1}, 32'd0);
            else                 check("nb_wr", {21'd0, cs1, wd1}, {21'd0, wq1.pop_front()});
        end
    end

    // From a negedge with the request already driven: cycles until ack and busy cycles seen.
    task automatic wait_ack(output int n, output int bcnt);
        n = 0;
        bcnt = 0;
        while (!(ack_a | ack_b) && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (busy) bcnt++;
        end
        if (n >= 40) check("ack_timeout", n, 32'd0);
    endtask

    task automatic do_xfer(input bit is_b, input logic [15:0] d, input string tag);
        int n, b;
        push_val(d, 1'b1, 1'b0);
        aq0.push_back(is_b ? 2'b01 : 2'b10);
        if (is_b) begin data_b = d; req_b = 1'b1; end
        else      begin data_a = d; req_a = 1'b1; end
        wait_ack(n, b);
        check({tag, "_latency"}, n, 32'd6);
        check({tag, "_busy_cycles"}, b, 32'd6);
        req_a = 1'b0;
        req_b = 1'b0;
        @(negedge clk);
        check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int n, b, t0;
        reset = 1'b1;
        req_a = 1'b0; req_b = 1'b0; data_a = '0; data_b = '0;
        req1_a = 1'b0; req1_b = 1'b0; data1_a = '0; data1_b = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_cs", {28'd0, cs}, 32'd0);
        check("rst_write_n", {31'd0, write_n}, 32'd1);
        check("rst_wd", {25'd0, wd}, 32'd0);
        check("rst_addr", {30'd0, addr}, 32'd0);
        check("rst_ack", {30'd0, ack_a, ack_b}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);

        do_xfer(1'b0, 16'h1234, "a_1234");
        do_xfer(1'b1, 16'h0050, "b_0050");
        do_xfer(1'b1, 16'h0000, "b_0000");
        do_xfer(1'b0, 16'h0A08, "a_0A08");

        // Both requests rise together after reset and stay held: A, B, A, B.
        do_reset();
        data_a = 16'h00A0;
        data_b = 16'h9876;
        for (int k = 0; k < 2; k++) begin
            push_val(16'h00A0, 1'b1, 1'b0); aq0.push_back(2'b10);
            push_val(16'h9876, 1'b1, 1'b0); aq0.push_back(2'b01);
        end
        ack_cyc.delete();
        req_a = 1'b1;
        req_b = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_ack(n, b);
            if (k == 3) begin req_a = 1'b0; req_b = 1'b0; end
            @(negedge clk);
        end
        check("rr_ack_count", ack_cyc.size(), 32'd4);
        if (ack_cyc.size() == 4)
            for (int k = 1; k < 4; k++) check("rr_spacing", ack_cyc[k] - ack_cyc[k-1], 32'd7);

        // Leading blanking disabled: every digit shown.
        push_val(16'h0007, 1'b0, 1'b1);
        data1_a = 16'h0007;
        req1_a = 1'b1;
        n = 0;
        while (!ack1_a && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) check("nb_ack_timeout", n, 32'd0);
        req1_a = 1'b0;
        @(negedge clk);

        // Reset while digit 2 is being written: remaining writes and ack abandoned.
        push_val(16'h1234, 1'b1, 1'b0);
        void'(wq0.pop_back());
        data_a = 16'h1234;
        req_a = 1'b1;
        n = 0;
        while (!(!write_n && cs == 4'b0100) && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) check("digit2_timeout", n, 32'd0);
        reset = 1'b1;
        req_a = 1'b0;
        @(negedge clk);
        check("midrst_cs", {28'd0, cs}, 32'd0);
        check("midrst_write_n", {31'd0, write_n}, 32'd1);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_ack", {30'd0, ack_a, ack_b}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // After reset A has priority again over a simultaneous B.
        push_val(16'h0321, 1'b1, 1'b0); aq0.push_back(2'b10);
        push_val(16'h0042, 1'b1, 1'b0); aq0.push_back(2'b01);
        data_a = 16'h0321;
        data_b = 16'h0042;
        req_a = 1'b1;
        req_b = 1'b1;
        wait_ack(n, b);
        req_a = 1'b0;
        @(negedge clk);
        wait_ack(n, b);
        req_b = 1'b0;
        @(negedge clk);

        // Input change during WRITE must not disturb the latched value.
        push_val(16'h1234, 1'b1, 1'b0); aq0.push_back(2'b10);
        data_a = 16'h1234;
        req_a = 1'b1;
        t0 = 0;
        while (write_n && t0 < 40) begin @(negedge clk); t0++; end
        if (t0 >= 40) check("write_timeout", t0, 32'd0);
        data_a = 16'h9999;
        wait_ack(n, b);
        req_a = 1'b0;

        repeat (12) @(negedge clk);
        check("wq_empty", wq0.size(), 32'd0);
        check("nb_wq_empty", wq1.size(), 32'd0);
        check("aq_empty", aq0.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
